// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//
//   Pipeline -> controller : ID_rs, ID_rt, EX_memRead, EX_writeReg, MEM_M,
//                            dm_ready, branch_taken
//   Controller -> pipeline : PC_en, IF_ID_en, EX_MEM_en, IF_ID_flush,
//                            ID_EX_bubble, MEM_WB_bubble, state, dm_err
//
// modport master : the pipeline side (drives hazard inputs, observes controls)
// modport slave  : the hazard controller
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       EX_memRead;
  logic [4:0] EX_writeReg;
  logic [1:0] MEM_M;
  logic       dm_ready;
  logic       branch_taken;

  logic       PC_en;
  logic       IF_ID_en;
  logic       EX_MEM_en;
  logic       IF_ID_flush;
  logic       ID_EX_bubble;
  logic       MEM_WB_bubble;
  logic [1:0] state;
  logic       dm_err;

  modport master (
    output ID_rs, ID_rt, EX_memRead, EX_writeReg, MEM_M, dm_ready, branch_taken,
    input  PC_en, IF_ID_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble,
           state, dm_err
  );

  modport slave (
    input  ID_rs, ID_rt, EX_memRead, EX_writeReg, MEM_M, dm_ready, branch_taken,
    output PC_en, IF_ID_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble,
           state, dm_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: data-memory wait freeze with timeout abort,
// taken-branch flush, and load-use stall. Control outputs are a Mealy
// function of the FSM state and the current inputs (zero latency); state and
// the sticky dm_err flag are registered.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : asynchronous active-low reset
//   hz     : hazard_ctrl_if.slave (hazard inputs in, stage controls out)
//   stall_cycles, flush_count : 16-bit saturating performance counters,
//            present only when HAZARD_PERF_CNT_EN is defined
//
// Parameter
//   DM_TIMEOUT : number of MEM_WAIT cycles tolerated before the access is
//                dropped and dm_err is raised
//
// Configuration macro: HAZARD_PERF_CNT_EN
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int DM_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cycles,
  output logic [15:0]   flush_count
`endif
);

  localparam int CW = (DM_TIMEOUT < 1) ? 1 : $clog2(DM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(DM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic            dm_err_reg, dm_err_next;

  logic pc_en, if_id_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble;
  logic mem_wait, load_use, timeout;

  assign mem_wait = (hz.MEM_M != 2'b00) && !hz.dm_ready;
  assign load_use = hz.EX_memRead && (hz.EX_writeReg != 5'd0) &&
                    ((hz.EX_writeReg == hz.ID_rs) || (hz.EX_writeReg == hz.ID_rt));
  // wait_cnt_reg counts completed MEM_WAIT cycles; the access is dropped on
  // the cycle after DM_TIMEOUT of them have elapsed without dm_ready.
  assign timeout  = (wait_cnt_reg == TIMEOUT_VAL);

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    dm_err_next   = dm_err_reg;

    case (state_reg)
      RUN: begin
        if (mem_wait) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = '0;
          state_next    = MEM_WAIT;
        end else if (hz.branch_taken) begin
          // Branch outranks load-use: the stalled instruction is wrong-path.
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          state_next    = FLUSH;
        end else if (load_use) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_bubble  = 1'b1;
        end
      end

      MEM_WAIT: begin
        // EX is frozen here, so branch_taken is stale and ignored.
        if (hz.dm_ready) begin
          state_next    = RUN;
        end else if (timeout) begin
          // Drop the access: let EX advance, retire a bubble from MEM.
          mem_wb_bubble = 1'b1;
          dm_err_next   = 1'b1;
          state_next    = RUN;
        end else begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end

      FLUSH: begin
        if (mem_wait) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = '0;
          state_next    = MEM_WAIT;
        end else begin
          if_id_flush   = 1'b1;
          state_next    = RUN;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    // Outputs must sit at their defaults for the whole reset assertion,
    // regardless of what the pipeline is presenting.
    if (!rst) begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      ex_mem_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      dm_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      dm_err_reg   <= dm_err_next;
    end
  end

  assign hz.PC_en         = pc_en;
  assign hz.IF_ID_en      = if_id_en;
  assign hz.EX_MEM_en     = ex_mem_en;
  assign hz.IF_ID_flush   = if_id_flush;
  assign hz.ID_EX_bubble  = id_ex_bubble;
  assign hz.MEM_WB_bubble = mem_wb_bubble;
  assign hz.state         = state_reg;
  assign hz.dm_err        = dm_err_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= 16'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      if (!pc_en && (stall_cycles_reg != 16'hFFFF))
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      // FLUSH never follows FLUSH, so any transition into it is an entry.
      if ((state_next == FLUSH) && (state_reg != FLUSH) &&
          (flush_count_reg != 16'hFFFF))
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed test of hazard_ctrl: reset defaults, load-use stall, memory wait
// freeze/release, branch-over-load-use priority, memory wait during FLUSH,
// dm_ready on the timeout cycle, timeout abort with sticky dm_err, and reset
// asserted mid MEM_WAIT.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  logic [15:0] stall_base;
`endif

  hazard_ctrl #(.DM_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_en, IF_ID_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble}
  localparam logic [5:0] O_DEF    = 6'b111_000;
  localparam logic [5:0] O_LU     = 6'b001_010;
  localparam logic [5:0] O_FREEZE = 6'b000_001;
  localparam logic [5:0] O_BR     = 6'b111_110;
  localparam logic [5:0] O_FLUSH  = 6'b111_100;
  localparam logic [5:0] O_ABORT  = 6'b111_001;

  function automatic logic [5:0] outs();
    return {hif.PC_en, hif.IF_ID_en, hif.EX_MEM_en,
            hif.IF_ID_flush, hif.ID_EX_bubble, hif.MEM_WB_bubble};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] o,
                           input logic [1:0] st, input logic err);
    check({tag, ".outs"},   32'(outs()),      32'(o));
    check({tag, ".state"},  32'(hif.state),   32'(st));
    check({tag, ".dm_err"}, 32'(hif.dm_err),  32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.ID_rs        = 5'd0;
    hif.ID_rt        = 5'd0;
    hif.EX_memRead   = 1'b0;
    hif.EX_writeReg  = 5'd0;
    hif.MEM_M        = 2'b00;
    hif.dm_ready     = 1'b0;
    hif.branch_taken = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_inputs();

    // Reset: defaults even with hazards presented on the inputs.
    hif.MEM_M = 2'b10;
    hif.EX_memRead = 1'b1; hif.EX_writeReg = 5'd5; hif.ID_rs = 5'd5;
    #1;
    check_all("reset_hazard_in", O_DEF, 2'b00, 1'b0);
    step();
    check_all("reset_after_edge", O_DEF, 2'b00, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
`endif
    clear_inputs();
    step();
    rst = 1'b1;
    #1;

    // Load-use on rs.
    hif.EX_memRead = 1'b1; hif.EX_writeReg = 5'd5; hif.ID_rs = 5'd5;
    #1;
    check_all("lu_rs", O_LU, 2'b00, 1'b0);
    step();
    check("lu_rs_state_after", 32'(hif.state), 32'd0);
    // Load-use on rt.
    hif.ID_rs = 5'd3; hif.ID_rt = 5'd7; hif.EX_writeReg = 5'd7;
    #1;
    check("lu_rt", 32'(outs()), 32'(O_LU));
    // Destination r0 never stalls.
    hif.EX_writeReg = 5'd0; hif.ID_rs = 5'd0;
    #1;
    check("lu_r0", 32'(outs()), 32'(O_DEF));
    // No match / not a load.
    hif.EX_writeReg = 5'd9; hif.ID_rs = 5'd9; hif.EX_memRead = 1'b0;
    #1;
    check("lu_not_load", 32'(outs()), 32'(O_DEF));
    clear_inputs();
    step();

    // Memory wait: dm_ready low 3 cycles, then high.
    hif.MEM_M = 2'b10;
    #1;
    check_all("mw_c1", O_FREEZE, 2'b00, 1'b0);
    step();
    hif.branch_taken = 1'b1;   // ignored while frozen
    #1;
    check_all("mw_c2", O_FREEZE, 2'b01, 1'b0);
    step();
    hif.branch_taken = 1'b0;
    check_all("mw_c3", O_FREEZE, 2'b01, 1'b0);
    step();
    hif.dm_ready = 1'b1;
    #1;
    check_all("mw_c4_release", O_DEF, 2'b01, 1'b0);
    step();
    clear_inputs();
    #1;
    check_all("mw_after", O_DEF, 2'b00, 1'b0);

    // Branch coincident with load-use: branch wins, then one FLUSH cycle.
    hif.branch_taken = 1'b1;
    hif.EX_memRead = 1'b1; hif.EX_writeReg = 5'd5; hif.ID_rs = 5'd5;
    #1;
    check_all("br_lu", O_BR, 2'b00, 1'b0);
    step();
    check_all("br_flush", O_FLUSH, 2'b10, 1'b0);
    step();
    clear_inputs();
    #1;
    check_all("br_back_run", O_DEF, 2'b00, 1'b0);

    // Memory wait arriving during FLUSH takes priority.
    hif.branch_taken = 1'b1;
    step();
    hif.branch_taken = 1'b0;
    hif.MEM_M = 2'b01;
    #1;
    check_all("flush_mw", O_FREEZE, 2'b10, 1'b0);
    step();
    hif.dm_ready = 1'b1;
    #1;
    check_all("flush_mw_release", O_DEF, 2'b01, 1'b0);
    step();
    clear_inputs();
    #1;
    check("flush_mw_run", 32'(hif.state), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("flush_cnt_2", 32'(flush_count), 32'd2);
`endif

    // dm_ready on the timeout cycle completes normally.
    hif.MEM_M = 2'b10;
    step();
    for (int i = 0; i < 8; i++) begin
      check(i == 0 ? "rdy_to_frz_first" : "rdy_to_frz", 32'(outs()), 32'(O_FREEZE));
      step();
    end
    hif.dm_ready = 1'b1;
    #1;
    check_all("rdy_at_timeout", O_DEF, 2'b01, 1'b0);
    step();
    clear_inputs();
    #1;
    check_all("rdy_at_timeout_after", O_DEF, 2'b00, 1'b0);

    // Timeout abort.
    hif.MEM_M = 2'b10;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_frz_state", 32'(hif.state), 32'd1);
      check("to_frz_outs", 32'(outs()), 32'(O_FREEZE));
      step();
    end
    check_all("to_abort", O_ABORT, 2'b01, 1'b0);
    step();
    clear_inputs();
    #1;
    check_all("to_after", O_DEF, 2'b00, 1'b1);
    step();
    step();
    check("to_sticky", 32'(hif.dm_err), 32'd1);

    // Reset asserted in MEM_WAIT cycle 2.
    hif.MEM_M = 2'b10;
`ifdef HAZARD_PERF_CNT_EN
    #1;
    stall_base = stall_cycles;
`endif
    step();
    step();
    check("rst_mid_pre_state", 32'(hif.state), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mid_stall_delta", 32'(stall_cycles - stall_base), 32'd2);
`endif
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_mid", O_DEF, 2'b00, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mid_stall_cnt", 32'(stall_cycles), 32'd0);
    check("rst_mid_flush_cnt", 32'(flush_count), 32'd0);
`endif
    clear_inputs();
    step();
    rst = 1'b1;
    // First edge after release evaluates RUN normally.
    hif.MEM_M = 2'b10;
    #1;
    check("post_rst_freeze", 32'(outs()), 32'(O_FREEZE));
    step();
    check("post_rst_state", 32'(hif.state), 32'd1);
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter DM_TIMEOUT, default 8, setting the maximum number of MEM_WAIT cycles before an abort.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports ID_rs and ID_rt, input, 5 each, the source registers of the instruction in ID.
REQ-005 The block SHALL have port EX_memRead, input, 1, set when the EX-stage instruction is a load.
REQ-006 The block SHALL have port EX_writeReg, input, 5, the destination register of the EX-stage instruction.
REQ-007 The block SHALL have port MEM_M, input, 2, the MEM-stage memory control ([1]=read, [0]=write).
REQ-008 The block SHALL have port dm_ready, input, 1, data-memory access complete this cycle.
REQ-009 The block SHALL have port branch_taken, input, 1, a taken branch resolved in EX.
REQ-010 The block SHALL have outputs PC_en, IF_ID_en, EX_MEM_en, 1 each, which are stage-register load enables.
REQ-011 The block SHALL have outputs IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, 1 each, which insert zero control into the named stage register.
REQ-012 The block SHALL have output state, 2, the current FSM state (RUN=00, MEM_WAIT=01, FLUSH=10).
REQ-013 The block SHALL have output dm_err, 1, a sticky memory-timeout flag.

Function
REQ-014 The default outputs SHALL be: all enables 1, all flush/bubble 0.
REQ-015 The outputs SHALL be a Mealy function of state and the current inputs; the decision applies in the same cycle, with zero latency.
REQ-016 In RUN, if MEM_M!=0 and dm_ready=0, the block SHALL drive PC_en=IF_ID_en=EX_MEM_en=0 and MEM_WB_bubble=1, and move to MEM_WAIT.
REQ-017 In RUN with no memory wait, if branch_taken=1, the block SHALL drive IF_ID_flush=1 and ID_EX_bubble=1, and move to FLUSH.
REQ-018 In RUN with no memory wait and no branch, if EX_memRead=1, EX_writeReg!=0, and EX_writeReg equals ID_rs or ID_rt, the block SHALL drive PC_en=0, IF_ID_en=0, ID_EX_bubble=1 for that cycle and stay in RUN.
REQ-019 The priority SHALL be: memory wait > branch > load-use; a branch coincident with load-use SHALL produce no load-use stall.
REQ-020 In MEM_WAIT, the freeze outputs of REQ-016 SHALL hold while dm_ready=0, and branch_taken SHALL be ignored (EX is frozen).
REQ-021 In MEM_WAIT with dm_ready=1, the block SHALL drive default outputs that cycle and return to RUN.
REQ-022 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-023 When the wait counter reaches DM_TIMEOUT with dm_ready=0, the block SHALL set dm_err=1, drive EX_MEM_en=1 with MEM_WB_bubble=1 (drop the access), and return to RUN.
REQ-024 dm_ready=1 on the same cycle the timeout is reached SHALL complete normally, with no error.
REQ-025 FLUSH SHALL last exactly one cycle with IF_ID_flush=1 and all enables 1, then return to RUN.
REQ-026 In FLUSH, branch_taken and load-use SHALL be ignored.
REQ-027 In FLUSH, a memory wait SHALL take priority and move the block to MEM_WAIT.
REQ-028 dm_err SHALL clear only on reset.

Reset
REQ-029 While rst=0, the block SHALL hold state=RUN, wait counter=0, dm_err=0, and outputs at the REQ-014 defaults.
REQ-030 Assertion of rst in any state, including mid-MEM_WAIT or mid-FLUSH, SHALL take effect immediately without a clock.
REQ-031 The first clock edge after rst rises SHALL evaluate RUN normally.

Configuration
REQ-032 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cycles (16) and flush_count (16).
REQ-033 stall_cycles SHALL increment each cycle PC_en=0.
REQ-034 flush_count SHALL increment on each entry to FLUSH.
REQ-035 stall_cycles and flush_count SHALL saturate at 16'hFFFF and reset to 0.
REQ-036 Without HAZARD_PERF_CNT_EN, the ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-037 Load-use: EX_memRead=1, EX_writeReg=5, ID_rs=5 -> one cycle with PC_en=0, IF_ID_en=0, ID_EX_bubble=1; state stays 00.
REQ-038 Memory wait: MEM_M=2'b10, dm_ready low for 3 cycles then high -> freeze for 3 cycles, release on cycle 4, state 01 then 00, dm_err=0.
REQ-039 Timeout: DM_TIMEOUT=8, dm_ready held 0 -> dm_err=1 after 8 wait cycles, MEM_WB_bubble=1, state 00, dm_err stays 1 until rst.
REQ-040 Priority: branch_taken=1 plus load-use match in RUN -> IF_ID_flush=1, ID_EX_bubble=1, PC_en=1, then one FLUSH cycle (state 10).
REQ-041 Reset mid-op: rst=0 during MEM_WAIT cycle 2 -> state 00 and default outputs immediately; with HAZARD_PERF_CNT_EN defined, stall_cycles=0.
